// File: rtl/wb_arbiter_pkg.sv
// Shared defaults and requester indices for the writeback arbiter.
package wb_arbiter_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned AREG_W_DEFAULT = 5;
    localparam int unsigned CNT_W_DEFAULT  = 16;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; owns the priority pointer, grant is combinational.
module rr_arb2
    import wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       hold_i,
    output logic [1:0] gnt_o,
    output logic       prio_o
);

    logic prio_q, prio_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        if (!hold_i) begin
            if (req_i[REQ_ALU] && req_i[REQ_LSU]) begin
                gnt_o = prio_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // Pointer moves to the loser of the current grant; idle cycles leave it alone.
    always_comb begin
        prio_d = prio_q;
        if (gnt_o[REQ_ALU]) begin
            prio_d = 1'b1;
        end else if (gnt_o[REQ_LSU]) begin
            prio_d = 1'b0;
        end
    end

    assign prio_o = prio_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results into one registered register-file write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned AREG_W = AREG_W_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [AREG_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_wd,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [AREG_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_wd,
    output logic              lsu_ready,
    input  logic              hold,
    output logic              rf_we,
    output logic [AREG_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wd,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [1:0]        gnt;
    logic              prio_unused;
    logic              rf_we_q, rf_we_d;
    logic [AREG_W-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Reset acts as an extra hold so nothing is accepted on a reset edge.
    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  ({lsu_valid, alu_valid}),
        .hold_i (hold | ~rst_n),
        .gnt_o  (gnt),
        .prio_o (prio_unused)
    );

    assign alu_ready = gnt[REQ_ALU];
    assign lsu_ready = gnt[REQ_LSU];

    always_comb begin
        rf_we_d = 1'b0;
        rf_rd_d = rf_rd_q;
        rf_wd_d = rf_wd_q;
        if (gnt[REQ_ALU]) begin
            rf_we_d = (alu_rd != '0);
            rf_rd_d = alu_rd;
            rf_wd_d = alu_wd;
        end else if (gnt[REQ_LSU]) begin
            rf_we_d = (lsu_rd != '0);
            rf_rd_d = lsu_rd;
            rf_wd_d = lsu_wd;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (alu_valid && lsu_valid && !hold && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_wd_q <= '0;
            cnt_q   <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            rf_rd_q <= rf_rd_d;
            rf_wd_q <= rf_wd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_rd        = rf_rd_q;
    assign rf_wd        = rf_wd_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: default instance plus a CNT_W=4 instance for saturation.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, lsu_valid, hold;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_wd, lsu_wd;
    logic        alu_ready, lsu_ready, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic [15:0] conflict_cnt;
    logic        alu_ready4, lsu_ready4, rf_we4;
    logic [4:0]  rf_rd4;
    logic [31:0] rf_wd4;
    logic [3:0]  conflict_cnt4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_wd       (alu_wd),
        .alu_ready    (alu_ready),
        .lsu_valid    (lsu_valid),
        .lsu_rd       (lsu_rd),
        .lsu_wd       (lsu_wd),
        .lsu_ready    (lsu_ready),
        .hold         (hold),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wd        (rf_wd),
        .conflict_cnt (conflict_cnt)
    );

    wb_arbiter #(.CNT_W(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_wd       (alu_wd),
        .alu_ready    (alu_ready4),
        .lsu_valid    (lsu_valid),
        .lsu_rd       (lsu_rd),
        .lsu_wd       (lsu_wd),
        .lsu_ready    (lsu_ready4),
        .hold         (hold),
        .rf_we        (rf_we4),
        .rf_rd        (rf_rd4),
        .rf_wd        (rf_wd4),
        .conflict_cnt (conflict_cnt4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and registers are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'h1111_1111;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_wd = 32'h0;
        #1;
        check("rst_alu_ready", alu_ready, 0);
        tick();
        tick();
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_rd", rf_rd, 0);
        check("rst_rf_wd", rf_wd, 0);
        check("rst_cnt", conflict_cnt, 0);

        // Single ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEAD_BEEF;
        rst_n = 1'b1;
        #1;
        check("t1_alu_ready", alu_ready, 1);
        check("t1_lsu_ready", lsu_ready, 0);
        tick();
        alu_valid = 1'b0;
        check("t1_rf_we", rf_we, 1);
        check("t1_rf_rd", rf_rd, 5);
        check("t1_rf_wd", rf_wd, 32'hDEAD_BEEF);
        tick();
        check("t1_rf_we_drop", rf_we, 0);
        check("t1_rf_rd_keep", rf_rd, 5);
        check("t1_rf_wd_keep", rf_wd, 32'hDEAD_BEEF);

        // Alternating grants under continuous contention
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'hA0A0_0001;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_wd = 32'h5050_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_alu_ready", alu_ready, (i % 2) == 0);
            check("t2_lsu_ready", lsu_ready, (i % 2) == 1);
            tick();
            check("t2_rf_we", rf_we, 1);
            check("t2_rf_rd", rf_rd, ((i % 2) == 0) ? 1 : 2);
            check("t2_rf_wd", rf_wd, ((i % 2) == 0) ? 32'hA0A0_0001 : 32'h5050_0002);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        check("t2_cnt", conflict_cnt, 4);
        check("t2_cnt4", conflict_cnt4, 4);

        // LSU write to r0: accepted, no write strobe
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'h0000_1234;
        #1;
        check("t3_lsu_ready", lsu_ready, 1);
        check("t3_alu_ready", alu_ready, 0);
        tick();
        lsu_valid = 1'b0;
        check("t3_rf_we", rf_we, 0);
        check("t3_rf_rd", rf_rd, 0);
        check("t3_rf_wd", rf_wd, 32'h0000_1234);

        // Lone ALU grant moves pointer to LSU, then contention under hold
        alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h0000_0333;
        tick();
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_wd = 32'h0000_0222;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_hold_alu_ready", alu_ready, 0);
            check("t4_hold_lsu_ready", lsu_ready, 0);
            tick();
            check("t4_hold_rf_we", rf_we, 0);
            check("t4_hold_cnt", conflict_cnt, 4);
        end
        hold = 1'b0;
        #1;
        check("t4_lsu_ready", lsu_ready, 1);
        check("t4_alu_ready", alu_ready, 0);
        tick();
        check("t4_rf_rd", rf_rd, 2);
        check("t4_rf_wd", rf_wd, 32'h0000_0222);
        check("t4_cnt", conflict_cnt, 5);

        // Reset on the cycle of an ALU grant
        alu_rd = 5'd1; alu_wd = 32'hCAFE_0001;
        #1;
        check("t5_alu_ready_pre", alu_ready, 1);
        rst_n = 1'b0;
        #1;
        check("t5_alu_ready_rst", alu_ready, 0);
        check("t5_lsu_ready_rst", lsu_ready, 0);
        tick();
        check("t5_rf_we", rf_we, 0);
        check("t5_cnt", conflict_cnt, 0);
        rst_n = 1'b1;
        #1;
        check("t5_first_alu", alu_ready, 1);
        check("t5_first_lsu", lsu_ready, 0);
        tick();
        check("t5_rf_rd", rf_rd, 1);
        check("t5_rf_wd", rf_wd, 32'hCAFE_0001);

        // Counter saturation on the narrow instance
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("t6_one_hot", alu_ready & lsu_ready, 0);
            tick();
            if (i == 13 || i == 14 || i == 19) begin
                check("t6_cnt4", conflict_cnt4, (i + 1 > 15) ? 15 : i + 1);
            end
        end
        check("t6_cnt16", conflict_cnt, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
